// File: rtl/traffic_phase_timer_if.sv
// Timer interface between the traffic/pedestrian controller and the phase timer.
// The controller (master) drives the phase and control inputs; the timer (slave) returns expiry strobes.
interface traffic_phase_timer_if;
    logic [2:0] traff_state;
    logic       restart;
    logic       enable;
    logic       timer_3s;
    logic       timer_30s;
    logic [5:0] elapsed_sec;

    modport master (
        output traff_state,
        output restart,
        output enable,
        input  timer_3s,
        input  timer_30s,
        input  elapsed_sec
    );

    modport slave (
        input  traff_state,
        input  restart,
        input  enable,
        output timer_3s,
        output timer_30s,
        output elapsed_sec
    );
endinterface

// File: rtl/traffic_phase_timer.sv
// Phase timer: counts seconds from the entry of each controller phase and emits
// one-cycle strobes at the short and long expiry points.
module traffic_phase_timer #(
    parameter int TICKS_PER_SEC = 10,
    parameter int SHORT_SEC     = 3,
    parameter int LONG_SEC      = 30
) (
    input  logic                  clk_out,
    input  logic                  reset,
    traffic_phase_timer_if.slave  bus
);

    localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PW-1:0] LAST_TICK = PW'(TICKS_PER_SEC - 1);
    localparam logic [5:0]    SHORT_V   = 6'(SHORT_SEC);
    localparam logic [5:0]    LONG_V    = 6'(LONG_SEC);

    logic [PW-1:0] prescaler, prescaler_d;
    logic [5:0]    elapsed_q, elapsed_d;
    logic [2:0]    state_q;
    logic          short_q, short_d;
    logic          long_q, long_d;
    logic          do_restart;

    // Strobes are derived from the value elapsed_sec is about to take, so they
    // line up with the edge on which the second boundary is crossed.
    always_comb begin
        prescaler_d = prescaler;
        elapsed_d   = elapsed_q;
        short_d     = 1'b0;
        long_d      = 1'b0;
        do_restart  = (bus.traff_state != state_q) || bus.restart;

        if (do_restart) begin
            prescaler_d = '0;
            elapsed_d   = '0;
        end else if (bus.enable && (elapsed_q < LONG_V)) begin
            if (prescaler == LAST_TICK) begin
                prescaler_d = '0;
                elapsed_d   = elapsed_q + 6'd1;
                short_d     = (elapsed_d == SHORT_V);
                long_d      = (elapsed_d == LONG_V);
            end else begin
                prescaler_d = prescaler + PW'(1);
            end
        end
    end

    // state_q tracks the phase even during reset so release never looks like a phase change.
    always_ff @(posedge clk_out) begin
        state_q <= bus.traff_state;
        if (!reset) begin
            prescaler <= '0;
            elapsed_q <= '0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
        end else begin
            prescaler <= prescaler_d;
            elapsed_q <= elapsed_d;
            short_q   <= short_d;
            long_q    <= long_d;
        end
    end

    assign bus.timer_3s    = short_q;
    assign bus.timer_30s   = long_q;
    assign bus.elapsed_sec = elapsed_q;

endmodule
